// File: rtl/pll_ctrl.sv
// PLL sequencer: pulses PLL reset, waits for lock with timeout, debounces lock, and applies new divider codes.
// Optional fail counter output enabled by defining PLL_CTRL_FAIL_CNT_EN.
module pll_ctrl #(
    parameter int         RST_CYCLES   = 16,
    parameter int         LOCK_TIMEOUT = 65535,
    parameter int         LOCK_STABLE  = 1024,
    parameter logic [5:0] DEF_IDSEL    = 6'd59,
    parameter logic [5:0] DEF_FBDSEL   = 6'd8,
    parameter logic [5:0] DEF_ODSEL    = 6'd62
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    output logic       pll_rst,
    output logic [5:0] idsel,
    output logic [5:0] fbdsel,
    output logic [5:0] odsel,
    input  logic       cfg_req,
    input  logic [5:0] cfg_idsel,
    input  logic [5:0] cfg_fbdsel,
    input  logic [5:0] cfg_odsel,
    output logic       cfg_ack,
    output logic       locked,
    output logic       dom_rst
`ifdef PLL_CTRL_FAIL_CNT_EN
    ,
    output logic [7:0] fail_cnt
`endif
);

    localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_P = (MAX_A > LOCK_STABLE) ? MAX_A : LOCK_STABLE;
    localparam int CNT_W = (MAX_P > 2) ? $clog2(MAX_P) : 1;

    // The counter runs down to zero, so each state loads its length minus one.
    localparam logic [CNT_W-1:0] RST_LOAD     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(LOCK_STABLE - 1);

    typedef enum logic [1:0] {
        PRST,
        WAIT_LOCK,
        DEBOUNCE,
        RUN
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [1:0]       sync_reg;
    logic [5:0]       idsel_reg;
    logic [5:0]       fbdsel_reg;
    logic [5:0]       odsel_reg;
    logic             cfg_ack_reg;
    logic             lk;
    logic             accept;

    assign lk     = sync_reg[1];
    assign accept = (state_reg == RUN) && cfg_req;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            PRST: begin
                if (cnt_reg == '0) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = TIMEOUT_LOAD;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (lk) begin
                    state_next = DEBOUNCE;
                    cnt_next   = STABLE_LOAD;
                end else if (cnt_reg == '0) begin
                    state_next = PRST;
                    cnt_next   = RST_LOAD;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            DEBOUNCE: begin
                if (!lk) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = TIMEOUT_LOAD;
                end else if (cnt_reg == '0) begin
                    state_next = RUN;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            RUN: begin
                // A pending request wins together with lock loss; both lead to PRST.
                if (cfg_req || !lk) begin
                    state_next = PRST;
                    cnt_next   = RST_LOAD;
                end
            end
            default: begin
                state_next = PRST;
                cnt_next   = RST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg    <= 2'b00;
            state_reg   <= PRST;
            cnt_reg     <= RST_LOAD;
            idsel_reg   <= DEF_IDSEL;
            fbdsel_reg  <= DEF_FBDSEL;
            odsel_reg   <= DEF_ODSEL;
            cfg_ack_reg <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[0], pll_lock};
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            cfg_ack_reg <= accept;
            if (accept) begin
                idsel_reg  <= cfg_idsel;
                fbdsel_reg <= cfg_fbdsel;
                odsel_reg  <= cfg_odsel;
            end
        end
    end

    assign pll_rst = (state_reg == PRST);
    assign locked  = (state_reg == RUN);
    assign dom_rst = ~locked;
    assign cfg_ack = cfg_ack_reg;
    assign idsel   = idsel_reg;
    assign fbdsel  = fbdsel_reg;
    assign odsel   = odsel_reg;

`ifdef PLL_CTRL_FAIL_CNT_EN
    logic       fail_evt;
    logic [7:0] fail_cnt_reg;

    // Timeout and lock loss belong to different states, so one event per cycle at most.
    assign fail_evt = ((state_reg == WAIT_LOCK) && !lk && (cnt_reg == '0)) ||
                      ((state_reg == RUN) && !lk);

    always_ff @(posedge clk) begin
        if (rst) begin
            fail_cnt_reg <= 8'd0;
        end else if (fail_evt && (fail_cnt_reg != 8'hFF)) begin
            fail_cnt_reg <= fail_cnt_reg + 8'd1;
        end
    end

    assign fail_cnt = fail_cnt_reg;
`endif

endmodule
